// File: rtl/dual_port_ram_param.sv
// True dual-port RAM, single clock; read data and valid appear 1+OUT_REG cycles after the access edge.
// No backpressure: each port accepts one access every cycle; same-address collisions are pulsed and counted.
module dual_port_ram_param #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 6,
  parameter int RD_MODE = 0,
  parameter int OUT_REG = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] q_a,
  output logic              vld_a,
  input  logic              en_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] data_b,
  output logic [DATA_W-1:0] q_b,
  output logic              vld_b,
  output logic              coll,
  output logic [15:0]       coll_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic wr_a, wr_b, rd_a, rd_b, same_addr, coll_hit;
  logic [DATA_W-1:0] rd_src_a, rd_src_b;

  assign wr_a      = en_a & we_a;
  assign wr_b      = en_b & we_b;
  assign rd_a      = en_a & ~we_a;
  assign rd_b      = en_b & ~we_b;
  assign same_addr = (addr_a == addr_b);
  assign coll_hit  = en_a & en_b & same_addr & (we_a | we_b);

  // Memory array is deliberately not reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (wr_a)
        mem[addr_a] <= data_a;
      if (wr_b && !(wr_a && same_addr))
        mem[addr_b] <= data_b;
    end
  end

  // Write-first mode forwards the other port's write data on an address match.
  always_comb begin
    rd_src_a = mem[addr_a];
    rd_src_b = mem[addr_b];
    if (RD_MODE == 1) begin
      if (wr_b && same_addr)
        rd_src_a = data_b;
      if (wr_a && same_addr)
        rd_src_b = data_a;
    end
  end

  logic              s1_vld_a, s1_vld_b;
  logic [DATA_W-1:0] s1_dat_a, s1_dat_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_a <= 1'b0;
      s1_vld_b <= 1'b0;
      s1_dat_a <= '0;
      s1_dat_b <= '0;
    end else begin
      s1_vld_a <= rd_a;
      s1_vld_b <= rd_b;
      if (rd_a)
        s1_dat_a <= rd_src_a;
      if (rd_b)
        s1_dat_b <= rd_src_b;
    end
  end

  generate
    if (OUT_REG == 1) begin : g_out_reg
      logic              s2_vld_a, s2_vld_b;
      logic [DATA_W-1:0] s2_dat_a, s2_dat_b;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s2_vld_a <= 1'b0;
          s2_vld_b <= 1'b0;
          s2_dat_a <= '0;
          s2_dat_b <= '0;
        end else begin
          s2_vld_a <= s1_vld_a;
          s2_vld_b <= s1_vld_b;
          if (s1_vld_a)
            s2_dat_a <= s1_dat_a;
          if (s1_vld_b)
            s2_dat_b <= s1_dat_b;
        end
      end

      assign q_a   = s2_dat_a;
      assign vld_a = s2_vld_a;
      assign q_b   = s2_dat_b;
      assign vld_b = s2_vld_b;
    end else begin : g_no_out_reg
      assign q_a   = s1_dat_a;
      assign vld_a = s1_vld_a;
      assign q_b   = s1_dat_b;
      assign vld_b = s1_vld_b;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coll     <= 1'b0;
      coll_cnt <= '0;
    end else begin
      coll <= coll_hit;
      if (coll_hit && coll_cnt != 16'hFFFF)
        coll_cnt <= coll_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_dual_port_ram_param.sv
// Directed bench: two instances share stimulus, d0 is read-first/1-cycle, d1 is write-first/2-cycle.
module tb_dual_port_ram_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       en_a, we_a, en_b, we_b;
  logic [5:0] addr_a, addr_b;
  logic [7:0] data_a, data_b;

  logic [7:0]  q_a0, q_b0, q_a1, q_b1;
  logic        vld_a0, vld_b0, vld_a1, vld_b1, coll0, coll1;
  logic [15:0] cnt0, cnt1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dual_port_ram_param #(.DATA_W(8), .ADDR_W(6), .RD_MODE(0), .OUT_REG(0)) d0 (
    .clk(clk), .rst(rst),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .data_a(data_a), .q_a(q_a0), .vld_a(vld_a0),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .data_b(data_b), .q_b(q_b0), .vld_b(vld_b0),
    .coll(coll0), .coll_cnt(cnt0)
  );

  dual_port_ram_param #(.DATA_W(8), .ADDR_W(6), .RD_MODE(1), .OUT_REG(1)) d1 (
    .clk(clk), .rst(rst),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .data_a(data_a), .q_a(q_a1), .vld_a(vld_a1),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .data_b(data_b), .q_b(q_b1), .vld_b(vld_b1),
    .coll(coll1), .coll_cnt(cnt1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en_a = 0; we_a = 0; en_b = 0; we_b = 0;
  endtask

  task automatic op_a(input logic we, input logic [5:0] ad, input logic [7:0] d);
    en_a = 1; we_a = we; addr_a = ad; data_a = d;
  endtask

  task automatic op_b(input logic we, input logic [5:0] ad, input logic [7:0] d);
    en_b = 1; we_b = we; addr_b = ad; data_b = d;
  endtask

  initial begin
    rst = 1; idle();
    addr_a = 0; addr_b = 0; data_a = 0; data_b = 0;
    tick(); tick();
    check("rst_q_a0",  32'(q_a0), 0);
    check("rst_vld_a0", 32'(vld_a0), 0);
    check("rst_q_b1",  32'(q_b1), 0);
    check("rst_vld_b1", 32'(vld_b1), 0);
    check("rst_coll0", 32'(coll0), 0);
    check("rst_cnt1",  32'(cnt1), 0);

    // Basic write then read on port A; the first edge after release must be honoured.
    rst = 0;
    op_a(1, 3, 8'h5A); tick();
    check("wr_no_vld0", 32'(vld_a0), 0);
    op_a(0, 3, 0); tick(); idle();
    check("rd_q_a0", 32'(q_a0), 32'h5A);
    check("rd_vld_a0", 32'(vld_a0), 1);
    check("rd_vld_a1_early", 32'(vld_a1), 0);
    tick();
    check("rd_vld_a0_pulse", 32'(vld_a0), 0);
    check("rd_q_a0_hold", 32'(q_a0), 32'h5A);
    check("rd_q_a1", 32'(q_a1), 32'h5A);
    check("rd_vld_a1", 32'(vld_a1), 1);
    tick();
    check("rd_vld_a1_pulse", 32'(vld_a1), 0);

    // Cross-port read during write.
    op_a(1, 7, 8'h11); tick();
    op_a(1, 7, 8'h22); op_b(0, 7, 0); tick(); idle();
    check("rdw_q_b0", 32'(q_b0), 32'h11);
    check("rdw_vld_b0", 32'(vld_b0), 1);
    check("rdw_coll0", 32'(coll0), 1);
    check("rdw_coll1", 32'(coll1), 1);
    check("rdw_cnt0", 32'(cnt0), 1);
    tick();
    check("rdw_q_b1", 32'(q_b1), 32'h22);
    check("rdw_vld_b1", 32'(vld_b1), 1);
    check("rdw_coll0_pulse", 32'(coll0), 0);
    op_a(0, 7, 0); tick(); idle();
    check("rdw_after_q_a0", 32'(q_a0), 32'h22);

    // Write-write collision on the top address: port A wins.
    op_a(1, 63, 8'hAA); op_b(1, 63, 8'hBB); tick(); idle();
    check("ww_coll0", 32'(coll0), 1);
    check("ww_cnt0", 32'(cnt0), 2);
    check("ww_cnt1", 32'(cnt1), 2);
    op_b(0, 63, 0); tick(); idle();
    check("ww_q_b0", 32'(q_b0), 32'hAA);
    tick();
    check("ww_q_b1", 32'(q_b1), 32'hAA);

    // Dual read of one address is not a collision.
    op_a(1, 5, 8'h3C); tick();
    op_a(0, 5, 0); op_b(0, 5, 0); tick(); idle();
    check("rr_q_a0", 32'(q_a0), 32'h3C);
    check("rr_q_b0", 32'(q_b0), 32'h3C);
    check("rr_coll0", 32'(coll0), 0);
    check("rr_cnt0", 32'(cnt0), 2);
    tick();
    check("rr_q_a1", 32'(q_a1), 32'h3C);
    check("rr_q_b1", 32'(q_b1), 32'h3C);

    // Writes to different addresses both land.
    op_a(1, 1, 8'h01); op_b(1, 2, 8'h02); tick(); idle();
    check("wd_coll0", 32'(coll0), 0);
    op_a(0, 2, 0); op_b(0, 1, 0); tick(); idle();
    check("wd_q_a0", 32'(q_a0), 32'h02);
    check("wd_q_b0", 32'(q_b0), 32'h01);

    // Disabled port ignores we/addr/data; then back-to-back reads.
    en_a = 0; we_a = 1; addr_a = 1; data_a = 8'hFF; tick();
    check("dis_vld_a0", 32'(vld_a0), 0);
    op_a(0, 1, 0); tick();
    check("b2b_q0", 32'(q_a0), 32'h01);
    op_a(0, 2, 0); tick(); idle();
    check("b2b_q1", 32'(q_a0), 32'h02);
    check("b2b_vld1", 32'(vld_a0), 1);
    check("b2b_q1_d1", 32'(q_a1), 32'h01);
    check("b2b_vld1_d1", 32'(vld_a1), 1);
    tick();
    check("b2b_q2_d1", 32'(q_a1), 32'h02);
    tick();

    // Reset while a 2-cycle read is in flight.
    op_a(0, 3, 0); tick(); idle();
    #3 rst = 1;
    #1;
    check("mid_vld_a1", 32'(vld_a1), 0);
    check("mid_q_a1", 32'(q_a1), 0);
    check("mid_q_a0", 32'(q_a0), 0);
    check("mid_cnt0", 32'(cnt0), 0);
    op_a(1, 3, 8'hEE); tick();
    check("mid_vld_a1_e1", 32'(vld_a1), 0);
    tick(); idle();
    check("mid_vld_a1_e2", 32'(vld_a1), 0);
    rst = 0;
    tick();
    check("post_vld_a1", 32'(vld_a1), 0);
    op_a(0, 3, 0); tick(); idle();
    check("post_q_a0", 32'(q_a0), 32'h5A);
    tick();
    check("post_q_a1", 32'(q_a1), 32'h5A);

    // Counter saturation.
    op_a(1, 9, 8'h00); op_b(0, 9, 0);
    repeat (65535) @(posedge clk);
    #1;
    check("sat_cnt0_full", 32'(cnt0), 32'hFFFF);
    repeat (2) @(posedge clk);
    #1;
    idle();
    check("sat_cnt0_hold", 32'(cnt0), 32'hFFFF);
    check("sat_cnt1_hold", 32'(cnt1), 32'hFFFF);
    check("sat_coll0", 32'(coll0), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
